multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one parameter: ILLEGAL_HALT, default 1, meaning 1 = an illegal instruction enters HALT and 0 = an illegal instruction is skipped.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be as follows:
- clk  input  1  clock; all state changes occur on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- op  input  7  instruction[6:0], taken from the instruction register.
- funct3  input  3  instruction[14:12].
- funct7b5  input  1  instruction[30].
- zero  input  1  ALU branch-condition flag; the ALU resolves it according to funct3.
- PCWrite  output  1  PC register write enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  output  1  data memory write enable.
- IRWrite  output  1  instruction register and OldPC write enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  ALU A select: 00 = PC, 01 = OldPC, 10 = rs1.
- ALUSrcB  output  2  ALU B select: 00 = rs2, 01 = ImmExt, 10 = constant 4.
- ALUOp  output  3  ALU operation: 000 = add, 001 = sub/branch, 010 = and, 011 = or, 101 = slt.
- ImmSrc  output  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- retire  output  1  one-cycle pulse in the final state of each instruction.
- illegal  output  1  sticky illegal-instruction flag.
- state  output  4  current state, for debug.

Function
REQ-004 The FSM SHALL use these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10, HALT=11.
REQ-005 The FSM SHALL make these transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR for op 0000011 (lw) or 0100011 (sw).
- DECODE -> EXECUTER for op 0110011.
- DECODE -> EXECUTEI for op 0010011.
- DECODE -> BRANCH for op 1100011.
- DECODE -> JAL for op 1101111.
- MEMADR -> MEMREAD for lw, and -> MEMWRITE for sw.
- MEMREAD -> MEMWB.
- EXECUTER and EXECUTEI -> ALUWB.
- JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
REQ-006 An instruction SHALL be illegal if any of the following holds:
- its op is not listed in REQ-005;
- it is a load or store with funct3 other than 010;
- it is a branch with funct3 not in {000, 001, 101};
- it is R-type with funct3 not in {000, 010, 110, 111};
- it is I-type with funct3 not in {000, 010, 110, 111}.
REQ-007 Illegal detection SHALL occur in DECODE. On detection, illegal is set to 1. If ILLEGAL_HALT=1 the next state is HALT; otherwise the next state is FETCH and retire pulses.
REQ-008 HALT SHALL persist until reset, with all enables held at 0.
REQ-009 Every output not named for a state SHALL be 0 in that state.
REQ-010 Per-state outputs SHALL be:
- FETCH: IRWrite=1, PCWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=000, ResultSrc=10.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=000 (branch/jump target).
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=000.
- MEMREAD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegWrite=1, retire=1.
- MEMWRITE: AdrSrc=1, MemWrite=1, retire=1.
- ALUWB: RegWrite=1, retire=1.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=001, PCWrite=zero, retire=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=000, PCWrite=1.
REQ-011 In EXECUTER, ALUSrcA SHALL be 10 and ALUSrcB 00. ALUOp SHALL be decoded from funct3 and funct7b5:
- funct3 000 with funct7b5=1 -> 001;
- funct3 000 with funct7b5=0 -> 000;
- funct3 010 -> 101;
- funct3 110 -> 011;
- funct3 111 -> 010.
REQ-012 In EXECUTEI, ALUSrcA SHALL be 10 and ALUSrcB 01. ALUOp SHALL be decoded from funct3 as in REQ-011, except that funct7b5 is ignored, so funct3 000 always gives 000.
REQ-013 ImmSrc SHALL be combinational from op in every state: 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, otherwise 00.
REQ-014 PCWrite in BRANCH SHALL be the only output that depends combinationally on zero. All other outputs SHALL depend on state, op, funct3 and funct7b5 only.
REQ-015 Latency, counted FETCH to retire inclusive, SHALL be: lw 5 cycles; sw, R-type, I-type and jal 4 cycles; branch 3 cycles.
REQ-016 In every state except FETCH, IRWrite SHALL be 0, so that op, funct3 and funct7b5 stay stable for the whole instruction.

Reset
REQ-017 While rst_n=0, state SHALL be FETCH, illegal SHALL be 0, and PCWrite, IRWrite, MemWrite, RegWrite and retire SHALL be forced to 0.
REQ-018 A reset asserted in any state, including mid-instruction or HALT, SHALL abort the instruction with no further writes. The first rising clk after rst_n deasserts SHALL execute FETCH.
REQ-019 Reset SHALL be the only means of clearing illegal.

Verification
REQ-020 Bench: reset release, then lw (op=0000011, funct3=010) -> states 0,1,2,3,4; RegWrite=1 and ResultSrc=01 in cycle 5; retire pulses once.
REQ-021 Bench: R-type, op=0110011, funct3=000, funct7b5=1 -> EXECUTER with ALUOp=001, ALUSrcB=00; ALUWB with RegWrite=1 in cycle 4.
REQ-022 Bench: branch, op=1100011, funct3=001, once with zero=1 and once with zero=0 -> BRANCH asserts PCWrite=1 and PCWrite=0 respectively; both return to FETCH after 3 cycles.
REQ-023 Bench: op=1111111 with ILLEGAL_HALT=1 -> DECODE then HALT (state=11), illegal=1, all enables 0 for 10 cycles; a rst_n pulse then restores FETCH with illegal=0.
REQ-024 Bench: sw, op=0100011, funct3=010, with rst_n pulled low while in MEMADR -> MemWrite never asserts; FETCH resumes on the first clk after release.
REQ-025 Bench: jal, op=1101111 -> ImmSrc=11 in DECODE; JAL state with PCWrite=1, ALUSrcA=01, ALUSrcB=10; ALUWB with RegWrite=1 in cycle 4.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and
// drives datapath selects and write enables for lw, sw, R/I-type ALU, beq/bne/bge and jal.
module multicycle_control #(
  parameter int ILLEGAL_HALT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       retire;
  } ctrl_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic HALT_ON_ILL = (ILLEGAL_HALT != 0);

  function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic sub);
    case (f3)
      3'b000:  alu_dec = sub ? 3'b001 : 3'b000;
      3'b010:  alu_dec = 3'b101;
      3'b110:  alu_dec = 3'b011;
      3'b111:  alu_dec = 3'b010;
      default: alu_dec = 3'b000;
    endcase
  endfunction

  function automatic logic is_illegal(input logic [6:0] o, input logic [2:0] f3);
    case (o)
      OP_LW, OP_SW: is_illegal = (f3 != 3'b010);
      OP_BR:        is_illegal = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101);
      OP_R, OP_I:   is_illegal = !(f3 == 3'b000 || f3 == 3'b010 ||
                                   f3 == 3'b110 || f3 == 3'b111);
      OP_JAL:       is_illegal = 1'b0;
      default:      is_illegal = 1'b1;
    endcase
  endfunction

  // Control word for the state about to be entered; registered so outputs
  // line up with state_q. Branch PCWrite is added combinationally from zero.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] f3,
                                     input logic f7b5);
    ctrl_t c;
    c = '0;
    case (st)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.pcwrite   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      MEMREAD:  c.adrsrc = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
        c.retire    = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
        c.retire   = 1'b1;
      end
      EXECUTER: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b00;
        c.aluop   = alu_dec(f3, f7b5);
      end
      EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = alu_dec(f3, 1'b0);
      end
      ALUWB: begin
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      BRANCH: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b00;
        c.aluop   = 3'b001;
        c.retire  = 1'b1;
      end
      JAL: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   illegal_q, illegal_d;
  logic   ill_dec;
  logic   skip_retire;

  always_comb begin
    ill_dec = is_illegal(op, funct3);
    state_d = state_q;
    case (state_q)
      FETCH: state_d = DECODE;
      DECODE: begin
        if (ill_dec) begin
          state_d = HALT_ON_ILL ? HALT : FETCH;
        end else begin
          case (op)
            OP_LW, OP_SW: state_d = MEMADR;
            OP_R:         state_d = EXECUTER;
            OP_I:         state_d = EXECUTEI;
            OP_BR:        state_d = BRANCH;
            OP_JAL:       state_d = JAL;
            default:      state_d = FETCH;
          endcase
        end
      end
      MEMADR:                        state_d = (op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:                       state_d = MEMWB;
      EXECUTER, EXECUTEI, JAL:       state_d = ALUWB;
      MEMWB, MEMWRITE, ALUWB, BRANCH: state_d = FETCH;
      HALT:                          state_d = HALT;
      default:                       state_d = FETCH;
    endcase
    ctrl_d    = ctrl_for(state_d, funct3, funct7b5);
    illegal_d = illegal_q | ((state_q == DECODE) & ill_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      ctrl_q    <= ctrl_for(FETCH, 3'b000, 1'b0);
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  // A skipped illegal instruction ends in DECODE, so its retire comes from op directly.
  assign skip_retire = !HALT_ON_ILL && (state_q == DECODE) && ill_dec;

  // Write enables are gated by rst_n so reset silences them immediately, while
  // the FETCH control word is already in place for the first edge after release.
  assign PCWrite   = rst_n & (ctrl_q.pcwrite | ((state_q == BRANCH) & zero));
  assign MemWrite  = rst_n & ctrl_q.memwrite;
  assign IRWrite   = rst_n & ctrl_q.irwrite;
  assign RegWrite  = rst_n & ctrl_q.regwrite;
  assign retire    = rst_n & (ctrl_q.retire | skip_retire);
  assign AdrSrc    = ctrl_q.adrsrc;
  assign ResultSrc = ctrl_q.resultsrc;
  assign ALUSrcA   = ctrl_q.alusrca;
  assign ALUSrcB   = ctrl_q.alusrcb;
  assign ALUOp     = ctrl_q.aluop;
  assign illegal   = illegal_q;
  assign state     = state_q;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule
